// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   owner_e  : tag that says which port a pipelined read belongs to.
//   AW_DEF / DW_DEF : default macro geometry (64 x 8).
//   WAIT_W   : width of the port B starvation counter (covers MAX_WAIT 1..15).
package sram_arb_pkg;

  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant decision for the two SRAM ports.
// Ports:
//   i_rr_mode : 1 = round-robin on contested cycles, 0 = fixed priority to A
//   i_a_req   : port A request
//   i_b_req   : port B request
//   i_b_force : fixed-priority mode, B has waited MAX_WAIT cycles
//   i_ptr_b   : round-robin mode, pointer currently favours B
//   o_a_gnt   : port A granted this cycle
//   o_b_gnt   : port B granted this cycle
// A lone requester is always granted; the mode inputs only matter when both
// ports request in the same cycle.
module sram_arb_pick (
  input  logic i_rr_mode,
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_b_force,
  input  logic i_ptr_b,
  output logic o_a_gnt,
  output logic o_b_gnt
);

  logic w_b_wins;

  // Who takes a contested cycle.
  assign w_b_wins = i_rr_mode ? i_ptr_b : i_b_force;

  assign o_a_gnt = i_a_req & ~(i_b_req & w_b_wins);
  assign o_b_gnt = i_b_req & ~(i_a_req & ~w_b_wins);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port 64x8 SRAM macro between the QCPU core (port A) and
// the Wishbone debug/load path (port B).
//
// Handshake (both ports): req is a level. While req=1 and gnt=0 the requester
// holds we/addr/wdata stable. The access is accepted in the cycle gnt=1; if
// req stays high the following cycle, that is a new access. One access per
// cycle in total.
//
// Ports:
//   wb_clk_i, rst_n            : clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  : port A request
//   a_gnt/a_rvalid/a_rdata     : port A grant (comb) and read return
//   b_*                        : port B, same meaning
//   sram_cen/sram_gwe          : macro chip/write enables, active low, registered
//   sram_addr/sram_in          : macro address and write data, registered
//   sram_out                   : macro read data (valid two cycles after gnt)
//
// Build option: define SRAM_ARB_RR_EN for round-robin on contested cycles;
// otherwise A has priority and B is force-granted after MAX_WAIT refusals.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          wb_clk_i,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          sram_cen,
  output logic          sram_gwe,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_in,
  input  logic [DW-1:0] sram_out
);

`ifdef SRAM_ARB_RR_EN
  localparam logic RR_MODE = 1'b1;
`else
  localparam logic RR_MODE = 1'b0;
`endif

  logic              r_cen;
  logic              r_gwe;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_in;
  owner_e            r_tag1;
  owner_e            r_tag2;
  logic [WAIT_W-1:0] r_wait;
  logic              r_ptr_b;

  logic          w_b_force;
  logic          w_any;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  owner_e        w_rd_own;

  // In round-robin builds the counter never leaves zero, so this stays low.
  assign w_b_force = ~RR_MODE & (r_wait == WAIT_W'(MAX_WAIT));

  sram_arb_pick u_pick (
    .i_rr_mode (RR_MODE),
    .i_a_req   (a_req),
    .i_b_req   (b_req),
    .i_b_force (w_b_force),
    .i_ptr_b   (r_ptr_b),
    .o_a_gnt   (a_gnt),
    .o_b_gnt   (b_gnt)
  );

  // Winner's fields; only meaningful when w_any is high.
  assign w_any   = a_gnt | b_gnt;
  assign w_we    = a_gnt ? a_we    : b_we;
  assign w_addr  = a_gnt ? a_addr  : b_addr;
  assign w_wdata = a_gnt ? a_wdata : b_wdata;

  always_comb begin
    w_rd_own = OWN_NONE;
    if (w_any && !w_we) w_rd_own = a_gnt ? OWN_A : OWN_B;
  end

  // Macro control pins plus the two-stage read-owner pipeline. Stage 2 lines
  // up with the cycle in which sram_out carries the data for that read.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cen  <= 1'b1;
      r_gwe  <= 1'b1;
      r_addr <= '0;
      r_in   <= '0;
      r_tag1 <= OWN_NONE;
      r_tag2 <= OWN_NONE;
    end else begin
      r_cen  <= ~w_any;
      r_tag1 <= w_rd_own;
      r_tag2 <= r_tag1;
      if (w_any) begin
        r_gwe  <= ~w_we;
        r_addr <= w_addr;
        r_in   <= w_wdata;
      end else begin
        r_gwe  <= 1'b1;
      end
    end
  end

  // Starvation counter (fixed priority) and round-robin pointer.
  // The counter cannot pass MAX_WAIT: at MAX_WAIT a requesting B is granted.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wait  <= '0;
      r_ptr_b <= 1'b0;
    end else begin
      if (RR_MODE || !b_req || b_gnt) r_wait <= '0;
      else                            r_wait <= r_wait + WAIT_W'(1);
      // Pointer moves to the port that did not just win.
      if (RR_MODE && w_any) r_ptr_b <= a_gnt;
    end
  end

  assign sram_cen  = r_cen;
  assign sram_gwe  = r_gwe;
  assign sram_addr = r_addr;
  assign sram_in   = r_in;

  assign a_rvalid = (r_tag2 == OWN_A);
  assign b_rvalid = (r_tag2 == OWN_B);
  assign a_rdata  = {DW{a_rvalid}} & sram_out;
  assign b_rdata  = {DW{b_rvalid}} & sram_out;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM macro model, reference model with an
// expected-read queue, directed scenarios and a randomized phase.
module tb_sram_port_arbiter;

  localparam int AW       = 6;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          sram_cen, sram_gwe;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_in;
  logic [DW-1:0] sram_out = '0;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .sram_cen (sram_cen),
    .sram_gwe (sram_gwe),
    .sram_addr(sram_addr),
    .sram_in  (sram_in),
    .sram_out (sram_out)
  );

  function automatic logic [DW-1:0] mem_init(input int i);
    return DW'(i * 37 + 11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM macro model ----------------
  logic [DW-1:0] mac_mem [64];
  bit            mac_ready = 1'b0;
  always @(posedge clk) begin
    if (!mac_ready) begin
      for (int i = 0; i < 64; i++) mac_mem[i] <= mem_init(i);
      mac_ready <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_gwe) mac_mem[sram_addr] <= sram_in;
      else           sram_out <= mac_mem[sram_addr];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] m_mem [64];
  bit            m_ready = 1'b0;
  int            cyc = 0;
  int            b_wait = 0;     // consecutive cycles B asked and was refused
  int            last_win = 1;   // 0 = A, 1 = B; A is favoured first
  logic [DW:0]   exp_q[$];       // {is_port_b, data}
  int            due_q[$];       // cycle in which the read must return
  logic          e_cen = 1'b1, e_gwe = 1'b1;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_in = '0;
  bit            m_a_gnt = 1'b0, m_b_gnt = 1'b0;

  always @(negedge clk) begin
    bit            ea, eb, wb, va, vb, we;
    logic [DW-1:0] ed, wd;
    logic [AW-1:0] ad;
    if (!m_ready) begin
      for (int i = 0; i < 64; i++) m_mem[i] = mem_init(i);
      m_ready = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_cen", sram_cen, 1);
      chk("rst_gwe", sram_gwe, 1);
      chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      b_wait = 0; last_win = 1;
      exp_q.delete(); due_q.delete();
      e_cen = 1'b1; e_gwe = 1'b1; e_addr = '0; e_in = '0;
      m_a_gnt = 1'b0; m_b_gnt = 1'b0;
    end else begin
      if (a_req && b_req) begin
`ifdef SRAM_ARB_RR_EN
        wb = (last_win == 0);
`else
        wb = (b_wait >= MAX_WAIT);
`endif
        ea = !wb; eb = wb;
      end else begin
        ea = a_req; eb = b_req;
      end
      va = 1'b0; vb = 1'b0; ed = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        vb = exp_q[0][DW];
        va = !vb;
        ed = exp_q[0][DW-1:0];
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      chk("a_gnt", a_gnt, ea);
      chk("b_gnt", b_gnt, eb);
      chk("a_rvalid", a_rvalid, va);
      chk("b_rvalid", b_rvalid, vb);
      chk("a_rdata", a_rdata, va ? ed : 8'h00);
      chk("b_rdata", b_rdata, vb ? ed : 8'h00);
      chk("sram_cen", sram_cen, e_cen);
      chk("sram_gwe", sram_gwe, e_gwe);
      chk("sram_addr", sram_addr, e_addr);
      chk("sram_in", sram_in, e_in);
      if (ea || eb) begin
        we = ea ? a_we : b_we;
        ad = ea ? a_addr : b_addr;
        wd = ea ? a_wdata : b_wdata;
        if (we) m_mem[ad] = wd;
        else begin
          exp_q.push_back({eb, m_mem[ad]});
          due_q.push_back(cyc + 2);
        end
        e_cen = 1'b0; e_gwe = !we; e_addr = ad; e_in = wd;
        last_win = eb ? 1 : 0;
      end else begin
        e_cen = 1'b1; e_gwe = 1'b1;
      end
      if (b_req && !eb) b_wait++;
      else              b_wait = 0;
      m_a_gnt = ea; m_b_gnt = eb;
    end
    cyc++;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [9:0] seq;
    logic [9:0] seq_exp;
    int n, n2;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", sram_addr, 0);
    chk("reset_in", sram_in, 0);
    chk("reset_rdata", {a_rdata, b_rdata}, 0);

    // Both ports read continuously from reset release.
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seq[i] = b_gnt;
    end
`ifdef SRAM_ARB_RR_EN
    seq_exp = 10'b1010101010;
`else
    seq_exp = 10'b1000010000;
`endif
    chk("contest_seq", seq, seq_exp);

    // A writes 0xA5 to 3, then reads it back.
    @(posedge clk); #1;
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd3; a_wdata = 8'hA5;
    @(negedge clk); chk("a_wr_gnt", a_gnt, 1);
    @(posedge clk); #1 a_we = 1'b0;
    @(negedge clk); chk("a_rd_gnt", a_gnt, 1);
    @(posedge clk); #1 a_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("a_rd_valid", a_rvalid, 1);
    chk("a_rd_data", a_rdata, 8'hA5);
    chk("a_rd_b_quiet", b_rvalid, 0);

    // B writes 0x3C to 63 while A idle, then A reads 63.
    n = 0;
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'd63; b_wdata = 8'h3C;
    @(negedge clk); chk("b_wr_gnt", b_gnt, 1); n += int'(!sram_gwe);
    @(posedge clk); #1;
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd63;
    @(negedge clk); chk("a_rd63_gnt", a_gnt, 1); n += int'(!sram_gwe);
    @(posedge clk); #1 a_req = 1'b0;
    @(negedge clk); n += int'(!sram_gwe);
    @(posedge clk);
    @(negedge clk); n += int'(!sram_gwe);
    chk("a_rd63_data", a_rdata, 8'h3C);
    chk("gwe_low_cycles", n, 1);

    // Ten idle cycles.
    n = 0; n2 = 0;
    repeat (10) begin
      @(negedge clk);
      n  += int'(a_rvalid | b_rvalid);
      n2 += int'(!sram_cen);
    end
    chk("idle_rvalid", n, 0);
    chk("idle_cen_low", n2, 0);
    chk("idle_addr_hold", sram_addr, 63);

    // Reset one cycle after a granted B read.
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd5;
    @(negedge clk); chk("b_rd_gnt", b_gnt, 1);
    @(posedge clk); #1 b_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_cen", sram_cen, 1);
    chk("rst_async_gwe", sram_gwe, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(a_rvalid | b_rvalid);
    end
    chk("post_rst_rvalid", n, 0);

    // Randomized traffic with changing request densities.
    for (int c = 0; c < 3000; c++) begin
      int pa, pb;
      pa = (c < 1000) ? 90 : ((c < 2000) ? 50 : 30);
      pb = (c < 1000) ? 90 : ((c < 2000) ? 30 : 60);
      @(posedge clk); #1;
      if (!(a_req && !m_a_gnt)) begin
        a_req   = ($urandom_range(0, 99) < pa);
        a_we    = ($urandom_range(0, 2) == 0);
        a_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
        a_wdata = DW'($urandom);
      end
      if (!(b_req && !m_b_gnt)) begin
        b_req   = ($urandom_range(0, 99) < pb);
        b_we    = ($urandom_range(0, 2) == 0);
        b_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
        b_wdata = DW'($urandom);
      end
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_queue", due_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
